// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU slice: loader states, fetch defaults,
// and the instruction/ALU encodings the loaded programs are built from.
package cpu_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  localparam logic [7:0] HLT_WORD = 8'hF0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  // Instruction opcode field [7:4]
  localparam logic [3:0] OP_LDI_R0 = 4'h0;
  localparam logic [3:0] OP_LDI_R1 = 4'h1;
  localparam logic [3:0] OP_ALU    = 4'h2;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // ALU operation select carried in the low bits of an ALU instruction
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_PASSA = 3'd5;
  localparam logic [2:0] ALU_PASSB = 3'd6;

endpackage

// File: rtl/instr_store.sv
// Instruction store: one synchronous write port for the loader and an
// asynchronous read port for the core's fetch. Contents are not reset.
module instr_store #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, XOR-checksummed program into the instruction
// store and holds the core in reset until the image has been verified.
module program_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = cpu_pkg::DEF_ADDR_W,
  parameter int DATA_W = cpu_pkg::DEF_DATA_W,
  parameter logic [DATA_W-1:0] HLT_WORD = DATA_W'(cpu_pkg::HLT_WORD)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   prog_len
);

  import cpu_pkg::*;

  localparam logic [DATA_W:0] MAX_LEN = (DATA_W+1)'(DEPTH);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] acc_q;
  logic              xfer;
  logic              len_ok;
  logic              last_word;
  logic              clear;
  logic              cap_len;
  logic              advance;
  logic [DATA_W-1:0] mem_rd;

  assign xfer      = in_valid && in_ready;
  assign len_ok    = (in_data != '0) && ({1'b0, in_data} <= MAX_LEN);
  assign last_word = ({1'b0, ptr_q} == (prog_len - 1'b1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A start pulse wins over any transfer in the same cycle and restarts the load.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    cap_len = 1'b0;
    advance = 1'b0;
    if (start) begin
      state_d = LEN;
      clear   = 1'b1;
    end else begin
      case (state_q)
        LEN: begin
          if (xfer) begin
            if (len_ok) begin
              state_d = DATA;
              cap_len = 1'b1;
            end else begin
              state_d = ERR;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            advance = 1'b1;
            if (last_word) begin
              state_d = CSUM;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            state_d = (in_data == acc_q) ? RUN : ERR;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      acc_q     <= '0;
      prog_len  <= '0;
      in_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      in_ready  <= (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
      cpu_reset <= (state_d != RUN);
      load_done <= (state_d == RUN);
      load_err  <= (state_d == ERR);
      if (clear) begin
        ptr_q    <= '0;
        acc_q    <= '0;
        prog_len <= '0;
      end else begin
        if (cap_len) begin
          prog_len <= in_data[ADDR_W:0];
        end
        if (advance) begin
          ptr_q <= ptr_q + 1'b1;
          acc_q <= acc_q ^ in_data;
        end
      end
    end
  end

  instr_store #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_store (
    .clk    (clk),
    .we     (advance),
    .wr_addr(ptr_q),
    .wr_data(in_data),
    .rd_addr(rd_addr),
    .rd_data(mem_rd)
  );

  // A failed image keeps its length but must never be fetched.
  assign rd_data = (!load_err && ({1'b0, rd_addr} < prog_len)) ? mem_rd : HLT_WORD;

endmodule
